alu_ex: RTL

Single-issue integer execute unit directly downstream of the reservation station. Each cycle it accepts at most one ready instruction (operands, immediate, PC, ROB tag) and computes the RV32I ALU result, plus branch outcome and target when enabled. Results go into a 2-entry result queue and are presented to the ROB/CDB with a valid/ready handshake. A `clear` from the ROB flushes all in-flight work.

---
 rtl/alu_ex.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_ex.sv
// RV32I integer execute unit with a 2-entry result queue; branch/jump redirect is built only with ALU_EX_BRANCH_EN.
// Latency: an instruction accepted at edge N is visible at the head right after N when the queue was empty.
// Backpressure: in_ready depends only on queue occupancy, so out_ready has no combinational path to in_ready.
module alu_ex #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_v1,
  input  logic [DATA_W-1:0] in_v2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic              out_jump,
  output logic [ADDR_W-1:0] out_target
);

  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(26);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(27);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(28);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(29);

`ifdef ALU_EX_BRANCH_EN
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              jump;
    logic [ADDR_W-1:0] target;
  } res_t;
`else
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } res_t;
`endif

  res_t              q_mem [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;
  res_t              res;
  logic              is_imm;
  logic [DATA_W-1:0] opb;
  logic [4:0]        shamt;
  logic              push;
  logic              pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // I-type ALU ops take the immediate as second operand.
  assign is_imm = (in_op == OP_ADDI)  || (in_op == OP_SLTI) || (in_op == OP_SLTIU) ||
                  (in_op == OP_XORI)  || (in_op == OP_ORI)  || (in_op == OP_ANDI)  ||
                  (in_op == OP_SLLI)  || (in_op == OP_SRLI) || (in_op == OP_SRAI);
  assign opb    = is_imm ? in_imm : in_v2;
  assign shamt  = opb[4:0];

  always_comb begin
    res     = '0;
    res.tag = in_tag;
    case (in_op)
      OP_LUI:            res.data = in_imm;
      OP_AUIPC:          res.data = DATA_W'(in_pc + ADDR_W'(in_imm));
      OP_JAL, OP_JALR:   res.data = DATA_W'(in_pc + ADDR_W'(4));
      OP_ADD, OP_ADDI:   res.data = in_v1 + opb;
      OP_SUB:            res.data = in_v1 - in_v2;
      OP_SLL, OP_SLLI:   res.data = in_v1 << shamt;
      OP_SRL, OP_SRLI:   res.data = in_v1 >> shamt;
      OP_SRA, OP_SRAI:   res.data = $unsigned($signed(in_v1) >>> shamt);
      OP_SLT, OP_SLTI:   res.data = {{(DATA_W-1){1'b0}}, $signed(in_v1) < $signed(opb)};
      OP_SLTU, OP_SLTIU: res.data = {{(DATA_W-1){1'b0}}, in_v1 < opb};
      OP_AND, OP_ANDI:   res.data = in_v1 & opb;
      OP_OR, OP_ORI:     res.data = in_v1 | opb;
      OP_XOR, OP_XORI:   res.data = in_v1 ^ opb;
      default:           res.data = '0;
    endcase
`ifdef ALU_EX_BRANCH_EN
    case (in_op)
      OP_BEQ: res.jump = (in_v1 == in_v2);
      OP_BNE: res.jump = (in_v1 != in_v2);
      OP_BLT: res.jump = ($signed(in_v1) < $signed(in_v2));
      OP_BGE: res.jump = ($signed(in_v1) >= $signed(in_v2));
      OP_BLTU: res.jump = (in_v1 < in_v2);
      OP_BGEU: res.jump = (in_v1 >= in_v2);
      OP_JAL, OP_JALR: res.jump = 1'b1;
      default: res.jump = 1'b0;
    endcase
    case (in_op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL:
        res.target = in_pc + ADDR_W'(in_imm);
      OP_JALR: begin
        res.target = ADDR_W'(in_v1 + in_imm);
        res.target[0] = 1'b0;
      end
      default: res.target = '0;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      q_mem[0] <= '0;
      q_mem[1] <= '0;
    end else if (clear) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (rdy) begin
      if (push) begin
        q_mem[tail] <= res;
        tail        <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_tag  = q_mem[head].tag;
  assign out_data = q_mem[head].data;
`ifdef ALU_EX_BRANCH_EN
  assign out_jump   = q_mem[head].jump;
  assign out_target = q_mem[head].target;
`else
  assign out_jump   = 1'b0;
  assign out_target = '0;
`endif

endmodule
